mem_responder: RTL and testbench

- Word-addressed memory responder serving the multicycle CPU's unified instruction/data port: single address, write enable, write data, read data valid one cycle later.
- Also serves a host/debug port with a req/ack handshake, used for program preload and result readback.
- Contains the RAM array plus a small MMIO window: LED register, cycle counter, mailbox.

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/dp_ram_rf.sv | 33 +++
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Purpose: shared types and constants for the memory responder (word type, MMIO offsets, host FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_responder_pkg;

  typedef logic [31:0] word_t;

  // Word offsets from MMIO_BASE
  localparam int MMIO_LED  = 0;
  localparam int MMIO_CNT  = 1;
  localparam int MMIO_MBOX = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } host_state_t;

endpackage

// File: rtl/dp_ram_rf.sv
// Purpose: true dual-port register array, read-first on both ports, no reset on contents.
// Latency: 1 cycle, rdata at edge n+1 reflects contents before any write at edge n.
// Backpressure: none; both ports accept an access every cycle.
// Ports: clk; per port a/b: *_we, *_addr, *_wdata in, *_rdata out (registered).
// The caller must never write the same address from both ports in one cycle.
module dp_ram_rf
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 240
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  word_t             a_wdata,
  output word_t             a_rdata,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  word_t             b_wdata,
  output word_t             b_rdata
);

  word_t mem [DEPTH];

  // Reads use the pre-edge contents, which gives read-first behaviour for free.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Purpose: RAM + MMIO (LED, cycle counter, mailbox) behind a CPU port and a req/ack host port.
// Latency: CPU read data one edge after the address; host ack two edges after req is seen.
// Backpressure: CPU never stalls; host waits on ack and must drop req before the next request.
// Ports: clk, rst_n; cpu_we/cpu_addr/cpu_wdata in, cpu_rdata out;
//        host_req/host_we/host_addr/host_wdata in, host_ack/host_rdata/host_coll out; led out.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 8'hF0,
  parameter int                LED_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_ack,
  output logic [31:0]       host_rdata,
  output logic              host_coll,
  output logic [LED_W-1:0]  led
);

  localparam logic [ADDR_W-1:0] A_LED  = MMIO_BASE + ADDR_W'(MMIO_LED);
  localparam logic [ADDR_W-1:0] A_CNT  = MMIO_BASE + ADDR_W'(MMIO_CNT);
  localparam logic [ADDR_W-1:0] A_MBOX = MMIO_BASE + ADDR_W'(MMIO_MBOX);

  word_t       cycle_cnt;
  word_t       mbox;
  host_state_t state;

  word_t cpu_ram_rdata, host_ram_rdata;
  logic  cpu_sel_ram, host_sel_ram;
  word_t cpu_mmio_q, host_mmio_q;
  logic  coll_pend;

  function automatic word_t mmio_read(input logic [ADDR_W-1:0] a,
                                      input logic [LED_W-1:0]  l,
                                      input word_t             c,
                                      input word_t             m);
    word_t v;
    v = '0;
    if (a == A_LED)       v = word_t'(l);
    else if (a == A_CNT)  v = c;
    else if (a == A_MBOX) v = m;
    return v;
  endfunction

  logic cpu_is_ram, host_is_ram;
  logic host_go, host_wr, host_coll_now, host_wr_ok;

  assign cpu_is_ram  = (cpu_addr < MMIO_BASE);
  assign host_is_ram = (host_addr < MMIO_BASE);

  // The host access happens on the single edge where IDLE sees req.
  assign host_go       = (state == IDLE) && host_req;
  assign host_wr       = host_go && host_we;
  assign host_coll_now = host_wr && cpu_we && (cpu_addr == host_addr);
  assign host_wr_ok    = host_wr && !host_coll_now;

  dp_ram_rf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (int'(MMIO_BASE))
  ) u_ram (
    .clk     (clk),
    .a_we    (cpu_we && cpu_is_ram),
    .a_addr  (cpu_addr),
    .a_wdata (cpu_wdata),
    .a_rdata (cpu_ram_rdata),
    .b_we    (host_wr_ok && host_is_ram),
    .b_addr  (host_addr),
    .b_wdata (host_wdata),
    .b_rdata (host_ram_rdata)
  );

  // CPU read path: the RAM output register is not reset, so a registered
  // select (reset to MMIO) forces cpu_rdata to 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_sel_ram <= 1'b0;
      cpu_mmio_q  <= '0;
    end else begin
      cpu_sel_ram <= cpu_is_ram;
      cpu_mmio_q  <= cpu_is_ram ? '0 : mmio_read(cpu_addr, led, cycle_cnt, mbox);
    end
  end

  assign cpu_rdata = cpu_sel_ram ? cpu_ram_rdata : cpu_mmio_q;

  // MMIO registers. CPU LED write beats a host LED write; a same-address
  // collision already suppresses the host write through host_wr_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      mbox      <= '0;
      led       <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (cpu_we && (cpu_addr == A_LED))
        led <= cpu_wdata[LED_W-1:0];
      else if (host_wr_ok && (host_addr == A_LED))
        led <= host_wdata[LED_W-1:0];
      if (host_wr_ok && (host_addr == A_MBOX))
        mbox <= host_wdata;
    end
  end

  // Host FSM. IDLE performs the access; ACK registers the read data and the
  // collision flag into the outputs, so ack/rdata/coll appear together in the
  // following cycle; WAIT_DROP blocks a held req from being served again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      host_ack     <= 1'b0;
      host_coll    <= 1'b0;
      host_rdata   <= '0;
      host_sel_ram <= 1'b0;
      host_mmio_q  <= '0;
      coll_pend    <= 1'b0;
    end else begin
      host_ack  <= 1'b0;
      host_coll <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            host_sel_ram <= host_is_ram;
            host_mmio_q  <= host_is_ram ? '0 : mmio_read(host_addr, led, cycle_cnt, mbox);
            coll_pend    <= host_coll_now;
            state        <= ACK;
          end
        end
        ACK: begin
          host_ack   <= 1'b1;
          host_coll  <= coll_pend;
          host_rdata <= host_sel_ram ? host_ram_rdata : host_mmio_q;
          state      <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!host_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_coll;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;

  mem_responder #(
    .ADDR_W    (8),
    .MMIO_BASE (8'hF0),
    .LED_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_coll  (host_coll),
    .led        (led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One host transaction; any CPU drive set up beforehand lasts for the access edge only.
  task automatic host_txn(input logic we, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic coll);
    int n;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    step();
    cpu_we = 1'b0;
    n = 1;
    while (!host_ack && n < 8) begin
      step();
      n++;
    end
    check("host_ack_latency", n, 2);
    rd   = host_rdata;
    coll = host_coll;
    host_req = 1'b0;
    step();
    check("host_ack_one_cycle", host_ack, 0);
  endtask

  logic [31:0] rd, v0;
  logic        coll;
  int          acks;

  initial begin
    rst_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_host_coll", host_coll, 0);
    check("rst_led", led, 0);
    rst_n = 1'b1;
    step();

    // CPU write/read, read-first on same-cycle write
    cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 32'h1234_5678; step();
    cpu_wdata = 32'hDEAD_BEEF; step();
    check("cpu_read_first", cpu_rdata, 32'h1234_5678);
    cpu_we = 1'b0; step();
    check("cpu_read_new", cpu_rdata, 32'hDEAD_BEEF);

    // Host preload with req held 5 extra cycles
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h00; host_wdata = 32'h2008_0004;
    step();
    check("preload_no_ack_edge1", host_ack, 0);
    step();
    check("preload_ack_edge2", host_ack, 1);
    check("preload_coll", host_coll, 0);
    acks = 0;
    repeat (5) begin
      step();
      if (host_ack) acks++;
    end
    check("held_req_single_ack", acks, 0);
    host_req = 1'b0; step(); step();
    cpu_addr = 8'h00; step();
    check("cpu_fetch_preload", cpu_rdata, 32'h2008_0004);
    host_txn(1'b0, 8'h05, 32'h0, rd, coll);
    check("host_read_ram", rd, 32'hDEAD_BEEF);

    // MMIO: LED
    cpu_we = 1'b1; cpu_addr = 8'hF0; cpu_wdata = 32'h0001_ABCD; step();
    check("led_write", led, 16'hABCD);
    cpu_we = 1'b0; step();
    check("led_readback", cpu_rdata, 32'h0000_ABCD);

    // Counter ignores writes
    cpu_addr = 8'hF1; step();
    v0 = cpu_rdata;
    cpu_we = 1'b1; cpu_wdata = 32'h0; step();
    check("cnt_write_ignored_1", cpu_rdata, v0 + 32'd1);
    cpu_we = 1'b0; step();
    check("cnt_write_ignored_2", cpu_rdata, v0 + 32'd2);

    // Mailbox: host writable, CPU read-only
    host_txn(1'b1, 8'hF2, 32'h0000_0055, rd, coll);
    cpu_addr = 8'hF2; step();
    check("mbox_read", cpu_rdata, 32'h0000_0055);
    cpu_we = 1'b1; cpu_wdata = 32'h0000_0099; step();
    cpu_we = 1'b0; step();
    check("mbox_cpu_write_ignored", cpu_rdata, 32'h0000_0055);
    host_txn(1'b0, 8'hF2, 32'h0, rd, coll);
    check("mbox_host_read", rd, 32'h0000_0055);
    cpu_addr = 8'hF7; step();
    check("mmio_unmapped", cpu_rdata, 32'h0);
    cpu_addr = 8'hFF; step();
    check("mmio_top_addr", cpu_rdata, 32'h0);

    // Collision: CPU wins
    cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'h0000_0011;
    host_txn(1'b1, 8'h10, 32'h0000_0022, rd, coll);
    check("coll_flag", coll, 1);
    cpu_addr = 8'h10; step();
    check("coll_cpu_wins", cpu_rdata, 32'h0000_0011);

    // Different addresses: both land
    cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'hA0A0_A0A0;
    host_txn(1'b1, 8'h21, 32'hB1B1_B1B1, rd, coll);
    check("nocoll_flag", coll, 0);
    cpu_addr = 8'h20; step();
    check("nocoll_cpu_data", cpu_rdata, 32'hA0A0_A0A0);
    cpu_addr = 8'h21; step();
    check("nocoll_host_data", cpu_rdata, 32'hB1B1_B1B1);

    // Counter wrap
    cpu_addr = 8'hF1;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    step();
    check("cnt_fffffffe", cpu_rdata, 32'hFFFF_FFFE);
    step();
    check("cnt_ffffffff", cpu_rdata, 32'hFFFF_FFFF);
    step();
    check("cnt_wrap_zero", cpu_rdata, 32'h0);

    // Reset during ACK aborts the ack; the committed write stays
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 32'h0000_0077;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", host_ack, 0);
    check("rst_mid_cpu_rdata", cpu_rdata, 0);
    check("rst_mid_led", led, 0);
    check("rst_mid_host_rdata", host_rdata, 0);
    host_req = 1'b0; cpu_addr = 8'hF1;
    step(); step();
    check("rst_hold_no_ack", host_ack, 0);
    rst_n = 1'b1;
    step();
    check("cnt_after_reset", cpu_rdata, 32'h0);
    cpu_addr = 8'h30; step();
    check("ram_survives_reset_new", cpu_rdata, 32'h0000_0077);
    check("no_ack_after_reset", host_ack, 0);
    cpu_addr = 8'h05; step();
    check("ram_survives_reset_old", cpu_rdata, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
